// File: rtl/corefifo_wr_ptr_gen_if.sv
// ---------------------------------------------------------------------------
// corefifo_wr_ptr_gen_if
// Bundles the write-side signals of the dual-clock FIFO write pointer
// generator so that the producer and the pointer block share one port.
//
// Signals:
//   wr_en        write request from the producer
//   rd_ptr_gray  read pointer in gray code, arriving from the read domain
//   wr_addr      RAM write address (low bits of the binary write pointer)
//   wr_ptr_gray  registered gray write pointer, sent to the read domain
//   wr_we        RAM write enable
//   full         FIFO full (registered)
//   afull        FIFO almost full (registered)
//   wr_cnt       write-side occupancy (registered)
//   overflow     one-cycle pulse when a write is rejected
//
// Modports:
//   master  the producer side (drives wr_en and rd_ptr_gray)
//   slave   the pointer generator itself
// ---------------------------------------------------------------------------
interface corefifo_wr_ptr_gen_if #(
    parameter int ADDRWIDTH = 3
);
    logic                 wr_en;
    logic [ADDRWIDTH:0]   rd_ptr_gray;
    logic [ADDRWIDTH-1:0] wr_addr;
    logic [ADDRWIDTH:0]   wr_ptr_gray;
    logic                 wr_we;
    logic                 full;
    logic                 afull;
    logic [ADDRWIDTH:0]   wr_cnt;
    logic                 overflow;

    modport master (
        output wr_en,
        output rd_ptr_gray,
        input  wr_addr,
        input  wr_ptr_gray,
        input  wr_we,
        input  full,
        input  afull,
        input  wr_cnt,
        input  overflow
    );

    modport slave (
        input  wr_en,
        input  rd_ptr_gray,
        output wr_addr,
        output wr_ptr_gray,
        output wr_we,
        output full,
        output afull,
        output wr_cnt,
        output overflow
    );
endinterface

// File: rtl/corefifo_wr_ptr_gen.sv
// ---------------------------------------------------------------------------
// corefifo_wr_ptr_gen
// Write-side pointer generator of the dual-clock FIFO, living entirely in
// the write clock domain. Keeps the binary write pointer, registers the gray
// copy that crosses to the read domain, synchronises the read domain's gray
// pointer back in, and produces full / almost-full / occupancy / overflow.
//
// Parameters:
//   ADDRWIDTH     RAM address width (DEPTH = 2**ADDRWIDTH), 2..16
//   SYNC_STAGES   flops in the rd_ptr_gray synchroniser, 2 or 3
//   AFULL_THRESH  occupancy at or above which afull asserts, 1..DEPTH
//
// Ports:
//   clk    write-domain clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    corefifo_wr_ptr_gen_if.slave (wr_en, rd_ptr_gray in; wr_addr,
//          wr_ptr_gray, wr_we, full, afull, wr_cnt, overflow out)
// ---------------------------------------------------------------------------
module corefifo_wr_ptr_gen #(
    parameter int ADDRWIDTH    = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    corefifo_wr_ptr_gen_if.slave   bus
);
    localparam int PW = ADDRWIDTH + 1;
    localparam logic [PW-1:0] DEPTH_C = {1'b1, {ADDRWIDTH{1'b0}}};
    localparam logic [PW-1:0] AFULL_C = PW'(AFULL_THRESH);

    logic [PW-1:0] wr_ptr_bin;
    logic [PW-1:0] wr_ptr_bin_next;
    logic [PW-1:0] wr_ptr_gray_q;
    logic [PW-1:0] wr_ptr_gray_next;
    logic [PW-1:0] rd_sync [SYNC_STAGES];
    logic [PW-1:0] rd_ptr_bin;
    logic [PW-1:0] occ_next;
    logic [PW-1:0] wr_cnt_q;
    logic          full_q;
    logic          afull_q;
    logic          overflow_q;
    logic          accept;

    // Gating with reset keeps the RAM from being written while the pointers
    // are held at zero, so a wr_en during reset is simply ignored.
    assign accept           = bus.wr_en & ~full_q & ~reset;
    assign wr_ptr_bin_next  = accept ? wr_ptr_bin + PW'(1) : wr_ptr_bin;
    assign wr_ptr_gray_next = wr_ptr_bin_next ^ (wr_ptr_bin_next >> 1);

    // Gray-to-binary of the last synchroniser stage: each binary bit is the
    // XOR of all gray bits from that position up to the MSB.
    always_comb begin
        rd_ptr_bin = '0;
        for (int i = 0; i < PW; i++) begin
            rd_ptr_bin[i] = ^(rd_sync[SYNC_STAGES-1] >> i);
        end
    end

    // Occupancy uses the pointer as it will be after this edge, so a write
    // shows up in the flags immediately and a write past DEPTH is impossible.
    assign occ_next = wr_ptr_bin_next - rd_ptr_bin;

    // Read pointer synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rd_sync[i] <= '0;
            end
        end else begin
            rd_sync[0] <= bus.rd_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rd_sync[i] <= rd_sync[i-1];
            end
        end
    end

    // Pointer, flag and count registers. The gray pointer is loaded straight
    // from the next binary value so exactly one bit flips per accepted write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_bin    <= '0;
            wr_ptr_gray_q <= '0;
            wr_cnt_q      <= '0;
            full_q        <= 1'b0;
            afull_q       <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_bin <= wr_ptr_bin_next;
            if (accept) begin
                wr_ptr_gray_q <= wr_ptr_gray_next;
            end
            wr_cnt_q   <= occ_next;
            full_q     <= (occ_next == DEPTH_C);
            afull_q    <= (occ_next >= AFULL_C);
            overflow_q <= bus.wr_en & full_q;
        end
    end

    assign bus.wr_addr     = wr_ptr_bin[ADDRWIDTH-1:0];
    assign bus.wr_ptr_gray = wr_ptr_gray_q;
    assign bus.wr_we       = accept;
    assign bus.full        = full_q;
    assign bus.afull       = afull_q;
    assign bus.wr_cnt      = wr_cnt_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_corefifo_wr_ptr_gen.sv
// ---------------------------------------------------------------------------
// tb_corefifo_wr_ptr_gen
// Self-checking bench for corefifo_wr_ptr_gen. Stimulus is driven on the
// falling edge; the expected post-edge outputs are queued at that moment and
// compared by a monitor just after the following rising edge.
// ---------------------------------------------------------------------------
module tb_corefifo_wr_ptr_gen;
    localparam int ADDRWIDTH    = 3;
    localparam int SYNC_STAGES  = 2;
    localparam int AFULL_THRESH = 6;
    localparam int PW           = ADDRWIDTH + 1;
    localparam int DEPTH        = 1 << ADDRWIDTH;
    localparam int PTR_MOD      = 1 << PW;

    typedef struct {
        int gray;
        int addr;
        int cnt;
        bit full;
        bit afull;
        bit ovf;
    } exp_t;

    logic clk;
    logic reset;

    corefifo_wr_ptr_gen_if #(.ADDRWIDTH(ADDRWIDTH)) bus ();

    corefifo_wr_ptr_gen #(
        .ADDRWIDTH    (ADDRWIDTH),
        .SYNC_STAGES  (SYNC_STAGES),
        .AFULL_THRESH (AFULL_THRESH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    // Reference model state (write pointer, delayed read pointer, full flag)
    int   m_bin;
    int   m_sync [SYNC_STAGES];
    bit   m_full;
    int   rd_cur;

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, check the combinational outputs, advance
    // the model to the state expected after the next rising edge and queue it.
    task automatic applyStimulus(input bit we, input int rd_bin);
        exp_t e;
        bit   acc;
        int   old_rd;
        int   occ;
        @(negedge clk);
        bus.wr_en       = we;
        bus.rd_ptr_gray = PW'(to_gray(rd_bin));
        #1;
        acc = we && !m_full;
        checkOutput("wr_we", int'(bus.wr_we), int'(acc));
        checkOutput("wr_addr", int'(bus.wr_addr), m_bin % DEPTH);
        old_rd = m_sync[SYNC_STAGES-1];
        for (int i = SYNC_STAGES - 1; i > 0; i--) begin
            m_sync[i] = m_sync[i-1];
        end
        m_sync[0] = rd_bin;
        e.ovf = we && m_full;
        if (acc) begin
            m_bin = (m_bin + 1) % PTR_MOD;
        end
        occ     = (m_bin - old_rd + PTR_MOD) % PTR_MOD;
        m_full  = (occ == DEPTH);
        e.gray  = to_gray(m_bin);
        e.addr  = m_bin % DEPTH;
        e.cnt   = occ;
        e.full  = m_full;
        e.afull = (occ >= AFULL_THRESH);
        sb.push_back(e);
    endtask

    task automatic clearModel();
        m_bin  = 0;
        m_full = 1'b0;
        rd_cur = 0;
        for (int i = 0; i < SYNC_STAGES; i++) begin
            m_sync[i] = 0;
        end
        sb.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gray"}, int'(bus.wr_ptr_gray), 0);
        checkOutput({tag, "_addr"}, int'(bus.wr_addr), 0);
        checkOutput({tag, "_cnt"}, int'(bus.wr_cnt), 0);
        checkOutput({tag, "_full"}, int'(bus.full), 0);
        checkOutput({tag, "_afull"}, int'(bus.afull), 0);
        checkOutput({tag, "_ovf"}, int'(bus.overflow), 0);
        checkOutput({tag, "_we"}, int'(bus.wr_we), 0);
    endtask

    // Scoreboard monitor: compares queued expectations just after each edge,
    // and flags any occupancy beyond DEPTH as an illegal state.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                checkOutput("sb_gray", int'(bus.wr_ptr_gray), mon_e.gray);
                checkOutput("sb_addr", int'(bus.wr_addr), mon_e.addr);
                checkOutput("sb_cnt", int'(bus.wr_cnt), mon_e.cnt);
                checkOutput("sb_full", int'(bus.full), int'(mon_e.full));
                checkOutput("sb_afull", int'(bus.afull), int'(mon_e.afull));
                checkOutput("sb_ovf", int'(bus.overflow), int'(mon_e.ovf));
            end
            if (int'(bus.wr_cnt) > DEPTH) begin
                checkOutput("occ_bound", int'(bus.wr_cnt), DEPTH);
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        int gray_seq [8];
        int budget;
        gray_seq = '{1, 3, 2, 6, 7, 5, 4, 12};

        // Reset and idle.
        reset           = 1'b1;
        bus.wr_en       = 1'b0;
        bus.rd_ptr_gray = '0;
        clearModel();
        #1;
        checkAllZero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) applyStimulus(1'b0, 0);

        // Eight back-to-back writes with the reader parked at zero.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 0);
            @(posedge clk);
            #2;
            checkOutput("fill_gray", int'(bus.wr_ptr_gray), gray_seq[i]);
            checkOutput("fill_cnt", int'(bus.wr_cnt), i + 1);
            checkOutput("fill_afull", int'(bus.afull), int'(i >= 5));
            checkOutput("fill_full", int'(bus.full), int'(i == 7));
        end

        // Writes against a full FIFO are rejected with an overflow pulse.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 0);
            @(posedge clk);
            #2;
            checkOutput("ovf_pulse", int'(bus.overflow), 1);
            checkOutput("ovf_gray", int'(bus.wr_ptr_gray), 12);
        end

        // Reader advances by one; full drops SYNC_STAGES+1 edges later.
        rd_cur = 1;
        for (int k = 0; k < SYNC_STAGES + 1; k++) begin
            applyStimulus(1'b0, rd_cur);
            @(posedge clk);
            #2;
            checkOutput("rd_full", int'(bus.full), int'(k < SYNC_STAGES));
        end
        checkOutput("rd_cnt", int'(bus.wr_cnt), DEPTH - 1);
        applyStimulus(1'b1, rd_cur);
        @(posedge clk);
        #2;
        checkOutput("refill_full", int'(bus.full), 1);

        // Writer and reader both run until the write pointer reaches 15.
        budget = 0;
        while (!(m_bin == PTR_MOD - 1 && !m_full) && budget < 200) begin
            if (rd_cur != m_bin) begin
                rd_cur = (rd_cur + 1) % PTR_MOD;
            end
            applyStimulus(1'b1, rd_cur);
            budget++;
        end
        if (budget >= 200) begin
            checkOutput("wrap_timeout", budget, 0);
        end
        applyStimulus(1'b1, rd_cur);
        @(posedge clk);
        #2;
        checkOutput("wrap_gray", int'(bus.wr_ptr_gray), 0);
        checkOutput("wrap_addr", int'(bus.wr_addr), 0);

        // Reset in the middle of a burst.
        @(negedge clk);
        reset           = 1'b1;
        bus.wr_en       = 1'b0;
        bus.rd_ptr_gray = '0;
        clearModel();
        @(negedge clk);
        reset = 1'b0;
        repeat (5) applyStimulus(1'b1, 0);
        @(posedge clk);
        #2;
        checkOutput("pre_reset_cnt", int'(bus.wr_cnt), 5);
        reset     = 1'b1;
        bus.wr_en = 1'b1;
        clearModel();
        #1;
        checkAllZero("async_reset");
        @(posedge clk);
        #1;
        checkOutput("reset_hold_gray", int'(bus.wr_ptr_gray), 0);
        @(negedge clk);
        reset     = 1'b0;
        bus.wr_en = 1'b0;
        applyStimulus(1'b1, 0);
        @(posedge clk);
        #2;
        checkOutput("post_reset_gray", int'(bus.wr_ptr_gray), 1);
        checkOutput("post_reset_addr", int'(bus.wr_addr), 1);

        @(posedge clk);
        #2;
        checkOutput("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/corefifo_wr_ptr_gen.md
Name: corefifo_wr_ptr_gen

Overview:
Write-side pointer generator for the dual-clock FIFO in the write clock domain. It keeps the binary write pointer and produces the registered gray-coded pointer that crosses to the read domain. It also synchronises the read domain's gray pointer, converts it back to binary, and generates full, almost-full, write occupancy and overflow. It is the producing end of the gray pointer crossing, whose consuming end is the read-side gray-to-binary conversion.

Parameters:
ADDRWIDTH, 3, RAM address width; DEPTH = 2^ADDRWIDTH; pointers are ADDRWIDTH+1 bits; legal range 2..16
SYNC_STAGES, 2, number of flops synchronising rd_ptr_gray; legal values 2 or 3
AFULL_THRESH, 6, occupancy at or above which afull asserts; legal range 1..DEPTH

Ports:
clk  input  1  write-domain clock, rising edge
reset  input  1  asynchronous, active-high reset
wr_en  input  1  write request
rd_ptr_gray  input  ADDRWIDTH+1  read pointer in gray code, from the read clock domain
wr_addr  output  ADDRWIDTH  RAM write address, equal to the lower ADDRWIDTH bits of the binary write pointer
wr_ptr_gray  output  ADDRWIDTH+1  registered gray write pointer, sent to the read domain
wr_we  output  1  RAM write enable (combinational: wr_en & ~full)
full  output  1  FIFO full, registered
afull  output  1  almost full, registered
wr_cnt  output  ADDRWIDTH+1  write-side occupancy, registered
overflow  output  1  one-cycle pulse when a write is rejected

Behaviour:
- The one clock is clk. Reset is asynchronous and active-high on reset. All registers clear while reset is high.
  - Reset values: wr_ptr_bin=0, wr_ptr_gray=0, sync stages=0, full=0, afull=0, wr_cnt=0, overflow=0.
  - wr_addr=0 during reset.
- Write acceptance: accept = wr_en & ~full. wr_we = accept; the RAM writes at wr_addr on the same edge.
- Pointer update on accept:
  - wr_ptr_bin_next = wr_ptr_bin + 1, modulo 2^(ADDRWIDTH+1), so 2*DEPTH-1 wraps to 0.
  - wr_ptr_gray <= wr_ptr_bin_next ^ (wr_ptr_bin_next >> 1). Gray is registered directly, never derived combinationally from wr_addr.
  - Without accept, both pointers hold.
- Gray output integrity: exactly one bit of wr_ptr_gray changes per accepted write. No other transitions occur outside reset.
- Read pointer synchronisation:
  - rd_ptr_gray passes through a chain of SYNC_STAGES flops.
  - The last stage is converted to rd_ptr_bin combinationally: bin[MSB] = gray[MSB]; bin[i] = bin[i+1] ^ gray[i].
- Flag and count computation:
  - occ_next = (wr_ptr_bin_next_or_held − rd_ptr_bin) mod 2^(ADDRWIDTH+1).
  - Registered each cycle: wr_cnt <= occ_next; full <= (occ_next == DEPTH); afull <= (occ_next >= AFULL_THRESH).
- Latency:
  - A write accepted at edge N is reflected in full, afull and wr_cnt immediately after edge N. This means no write beyond DEPTH is possible.
  - A change on rd_ptr_gray reaches the flags SYNC_STAGES+1 edges later, so full deasserts pessimistically.
- Overflow: if wr_en & full, overflow <= 1 for exactly one cycle. Pointers, wr_cnt and the RAM are unchanged. Otherwise overflow <= 0.
- Simultaneous events:
  - A write on the same cycle that a synchronised read pointer update lands nets out in occ_next; for example, occupancy stays constant.
  - full and afull may deassert and reassert on consecutive cycles as needed.
- Illegal input: occ_next > DEPTH cannot arise from a legal read side. In that case no flag behaviour is specified, and the bench treats it as an assertion failure.
- Reset mid-operation: everything returns to reset values asynchronously. Any wr_en during reset is ignored. The first accept after deassertion writes address 0.

Test Plan:
- Reset, then idle with rd_ptr_gray=0 → wr_ptr_gray=0, wr_cnt=0, full=0, afull=0, overflow=0.
- 8 back-to-back writes with rd_ptr_gray=0 (ADDRWIDTH=3):
  - wr_ptr_gray sequence is 1,3,2,6,7,5,4,12.
  - wr_addr sequence is 0..7.
  - afull=1 after the 6th write; full=1 after the 8th write; wr_cnt=8.
- With the FIFO full, hold wr_en=1 for 3 cycles → wr_we=0, overflow=1 on each of those 3 cycles, pointers frozen at bin 8 / gray 12.
- From full, drive rd_ptr_gray=1 (read bin 1) → full=0 and wr_cnt=7 exactly SYNC_STAGES+1 edges later; one further write makes full=1 again.
- Wrap-around with the reader tracking: advance to wr_ptr_bin=15 (gray 8), then one write → gray 0, bin 0, wr_addr 0, and wr_cnt is computed correctly across the wrap.
- Assert reset mid-burst with wr_cnt=5 → all outputs 0 immediately without waiting for a clock edge; a write after release goes to address 0, wr_ptr_gray=1.
